ahb_lite_interconnect: RTL

//  Parametrised single-master, N-slave AHB-Lite interconnect for the data path between riscv32ia ldst and its slaves.

---
 rtl/ahb_ic_pkg.sv | 19 +
 rtl/ahb_lite_interconnect_if.sv | 52 +++++
 rtl/ahb_default_slave.sv | 37 +++
 rtl/ahb_lite_interconnect.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ahb_ic_pkg.sv
// Shared encodings for the AHB-Lite interconnect: HTRANS/HRESP values and
// the default-slave state type.
package ahb_ic_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_t;

endpackage

// File: rtl/ahb_lite_interconnect_if.sv
// Bus bundle for the interconnect: master request/response plus per-slave fan-out.
// slave = interconnect side; master = environment side (master and slaves).
interface ahb_lite_interconnect_if #(
   parameter int NUM_SLAVES = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]                  m_haddr_in;
   logic [1:0]                             m_htrans_in;
   logic                                   m_hwrite_in;
   logic [2:0]                             m_hsize_in;
   logic [2:0]                             m_hburst_in;
   logic [3:0]                             m_hprot_in;
   logic                                   m_hmastlock_in;
   logic [DATA_WIDTH-1:0]                  m_hwdata_in;
   logic [DATA_WIDTH-1:0]                  m_hrdata_out;
   logic                                   m_hready_out;
   logic                                   m_hresp_out;

   logic [NUM_SLAVES-1:0]                  s_hsel_out;
   logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]  s_haddr_out;
   logic [NUM_SLAVES-1:0][1:0]             s_htrans_out;
   logic [NUM_SLAVES-1:0]                  s_hwrite_out;
   logic [NUM_SLAVES-1:0][2:0]             s_hsize_out;
   logic [NUM_SLAVES-1:0][2:0]             s_hburst_out;
   logic [NUM_SLAVES-1:0][3:0]             s_hprot_out;
   logic [NUM_SLAVES-1:0]                  s_hmastlock_out;
   logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  s_hwdata_out;
   logic [NUM_SLAVES-1:0]                  s_hready_out;
   logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  s_hrdata_in;
   logic [NUM_SLAVES-1:0]                  s_hready_in;
   logic [NUM_SLAVES-1:0]                  s_hresp_in;

   modport slave (
      input  m_haddr_in, m_htrans_in, m_hwrite_in, m_hsize_in, m_hburst_in,
             m_hprot_in, m_hmastlock_in, m_hwdata_in,
      output m_hrdata_out, m_hready_out, m_hresp_out,
      output s_hsel_out, s_haddr_out, s_htrans_out, s_hwrite_out, s_hsize_out,
             s_hburst_out, s_hprot_out, s_hmastlock_out, s_hwdata_out, s_hready_out,
      input  s_hrdata_in, s_hready_in, s_hresp_in
   );

   modport master (
      output m_haddr_in, m_htrans_in, m_hwrite_in, m_hsize_in, m_hburst_in,
             m_hprot_in, m_hmastlock_in, m_hwdata_in,
      input  m_hrdata_out, m_hready_out, m_hresp_out,
      input  s_hsel_out, s_haddr_out, s_htrans_out, s_hwrite_out, s_hsize_out,
             s_hburst_out, s_hprot_out, s_hmastlock_out, s_hwdata_out, s_hready_out,
      output s_hrdata_in, s_hready_in, s_hresp_in
   );

endinterface

// File: rtl/ahb_default_slave.sv
// Default slave: answers an unmapped transfer with a two-cycle ERROR
// (hready low then high, hresp high in both).
module ahb_default_slave
   import ahb_ic_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req_i,
   output logic hready_o,
   output logic hresp_o
);

   ds_state_t state_q, state_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= DS_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DS_IDLE: if (req_i) state_d = DS_ERR1;
         DS_ERR1: state_d = DS_ERR2;
         DS_ERR2: state_d = req_i ? DS_ERR1 : DS_IDLE;
         default: state_d = DS_IDLE;
      endcase
   end

   always_comb begin
      hready_o = 1'b1;
      hresp_o  = HRESP_OKAY;
      if (state_q == DS_ERR1) hready_o = 1'b0;
      if (state_q != DS_IDLE) hresp_o  = HRESP_ERROR;
   end

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master, N-slave AHB-Lite interconnect with a built-in ERROR default slave.
// Optional error log (err_* ports) enabled by defining AHB_IC_ERRLOG_EN.
module ahb_lite_interconnect
   import ahb_ic_pkg::*;
#(
   parameter int NUM_SLAVES = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE_ADDR = '0,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_LAST_ADDR = '0
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   ahb_lite_interconnect_if.slave bus
`ifdef AHB_IC_ERRLOG_EN
   ,
   output logic                  err_valid_out,
   output logic [ADDR_WIDTH-1:0] err_addr_out,
   output logic                  err_write_out,
   input  logic                  err_clr_in
`endif
);

   logic                  active, unmapped, ds_hready, ds_hresp;
   logic [NUM_SLAVES-1:0] hit;
   logic [NUM_SLAVES-1:0] dp_sel_q, dp_sel_d;
   logic                  dp_def_q, dp_def_d, dp_act_q, dp_act_d;

   assign active   = (bus.m_htrans_in == HTRANS_NONSEQ) || (bus.m_htrans_in == HTRANS_SEQ);
   assign unmapped = active & ~|hit;

   // Descending scan so the lowest matching index overwrites the others.
   always_comb begin
      hit = '0;
      for (int i = NUM_SLAVES-1; i >= 0; i--) begin
         if (bus.m_haddr_in >= SLAVE_BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] &&
             bus.m_haddr_in <= SLAVE_LAST_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
            hit    = '0;
            hit[i] = 1'b1;
         end
      end
   end

   assign bus.s_hsel_out   = (active && HRESETn) ? hit : '0;
   assign bus.s_hready_out = {NUM_SLAVES{bus.m_hready_out}};

   for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_bcast
      assign bus.s_haddr_out[g]     = bus.m_haddr_in;
      assign bus.s_htrans_out[g]    = bus.m_htrans_in;
      assign bus.s_hwrite_out[g]    = bus.m_hwrite_in;
      assign bus.s_hsize_out[g]     = bus.m_hsize_in;
      assign bus.s_hburst_out[g]    = bus.m_hburst_in;
      assign bus.s_hprot_out[g]     = bus.m_hprot_in;
      assign bus.s_hmastlock_out[g] = bus.m_hmastlock_in;
      assign bus.s_hwdata_out[g]    = bus.m_hwdata_in;
   end

   // Address phase is only accepted when the current data phase completes.
   always_comb begin
      dp_sel_d = dp_sel_q;
      dp_def_d = dp_def_q;
      dp_act_d = dp_act_q;
      if (bus.m_hready_out) begin
         dp_sel_d = hit;
         dp_def_d = unmapped;
         dp_act_d = active;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_sel_q <= '0;
         dp_def_q <= 1'b0;
         dp_act_q <= 1'b0;
      end else begin
         dp_sel_q <= dp_sel_d;
         dp_def_q <= dp_def_d;
         dp_act_q <= dp_act_d;
      end
   end

   ahb_default_slave u_default_slave (
      .clk_i    (HCLK),
      .rst_ni   (HRESETn),
      .req_i    (unmapped & bus.m_hready_out),
      .hready_o (ds_hready),
      .hresp_o  (ds_hresp)
   );

   always_comb begin
      bus.m_hready_out = 1'b1;
      bus.m_hresp_out  = HRESP_OKAY;
      bus.m_hrdata_out = '0;
      if (dp_def_q) begin
         bus.m_hready_out = ds_hready;
         bus.m_hresp_out  = ds_hresp;
      end else if (dp_act_q) begin
         for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dp_sel_q[i]) begin
               bus.m_hready_out = bus.s_hready_in[i];
               bus.m_hresp_out  = bus.s_hresp_in[i];
               bus.m_hrdata_out = bus.s_hrdata_in[i];
            end
         end
      end
   end

`ifdef AHB_IC_ERRLOG_EN
   logic [ADDR_WIDTH-1:0] dp_addr_q, dp_addr_d, err_addr_q, err_addr_d;
   logic                  dp_write_q, dp_write_d, err_valid_q, err_valid_d;
   logic                  err_write_q, err_write_d, err_cap;

   // A clear arriving with a fresh first-ERROR cycle re-arms the capture.
   assign err_cap = (bus.m_hresp_out == HRESP_ERROR) & ~bus.m_hready_out &
                    (~err_valid_q | err_clr_in);

   always_comb begin
      dp_addr_d   = bus.m_hready_out ? bus.m_haddr_in  : dp_addr_q;
      dp_write_d  = bus.m_hready_out ? bus.m_hwrite_in : dp_write_q;
      err_valid_d = err_valid_q & ~err_clr_in;
      err_addr_d  = err_addr_q;
      err_write_d = err_write_q;
      if (err_cap) begin
         err_valid_d = 1'b1;
         err_addr_d  = dp_addr_q;
         err_write_d = dp_write_q;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_addr_q   <= '0;
         dp_write_q  <= 1'b0;
         err_valid_q <= 1'b0;
         err_addr_q  <= '0;
         err_write_q <= 1'b0;
      end else begin
         dp_addr_q   <= dp_addr_d;
         dp_write_q  <= dp_write_d;
         err_valid_q <= err_valid_d;
         err_addr_q  <= err_addr_d;
         err_write_q <= err_write_d;
      end
   end

   assign err_valid_out = err_valid_q;
   assign err_addr_out  = err_addr_q;
   assign err_write_out = err_write_q;
`endif

endmodule
